// File: rtl/xlr8_irq_ctl.sv
// XLR8 vectored interrupt controller: up to eight sources, level/edge capture,
// fixed lowest-index priority, single outstanding request with ack holdoff.
module xlr8_irq_ctl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned XCTL_Address  = 0,
  parameter int unsigned XMSK_Address  = 0,
  parameter int unsigned XMODE_Address = 0,
  parameter int unsigned XIFR_Address  = 0,
  parameter int unsigned XVEC_Address  = 0,
  parameter int unsigned XHOLD_Address = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       adr,
  input  logic             iowe,
  input  logic             iore,
  input  logic [7:0]       dbus_in,
  output logic [7:0]       dbus_out,
  output logic             out_en,
  input  logic [7:0]       ramadr,
  input  logic             ramre,
  input  logic             ramwe,
  input  logic             dm_sel,
  input  logic [WIDTH-1:0] x_int_in,
  output logic             x_irq,
  output logic [2:0]       x_irq_vec,
  input  logic             x_irq_ack
);

  // Addresses at or above 0x60 live in data memory space, below it on the I/O bus.
  function automatic logic reg_hit(input int unsigned a, input logic [5:0] io_adr,
                                   input logic io_stb, input logic [7:0] dm_adr,
                                   input logic dm_stb, input logic dsel);
    if (a >= 32'h60) return dsel && dm_stb && (dm_adr == a[7:0]);
    return io_stb && (io_adr == a[5:0]);
  endfunction

  logic ctl_we, msk_we, mode_we, ifr_we, hold_we;
  logic ctl_re, msk_re, mode_re, ifr_re, vec_re, hold_re;

  assign ctl_we  = reg_hit(XCTL_Address,  adr, iowe, ramadr, ramwe, dm_sel);
  assign msk_we  = reg_hit(XMSK_Address,  adr, iowe, ramadr, ramwe, dm_sel);
  assign mode_we = reg_hit(XMODE_Address, adr, iowe, ramadr, ramwe, dm_sel);
  assign ifr_we  = reg_hit(XIFR_Address,  adr, iowe, ramadr, ramwe, dm_sel);
  assign hold_we = reg_hit(XHOLD_Address, adr, iowe, ramadr, ramwe, dm_sel);
  assign ctl_re  = reg_hit(XCTL_Address,  adr, iore, ramadr, ramre, dm_sel);
  assign msk_re  = reg_hit(XMSK_Address,  adr, iore, ramadr, ramre, dm_sel);
  assign mode_re = reg_hit(XMODE_Address, adr, iore, ramadr, ramre, dm_sel);
  assign ifr_re  = reg_hit(XIFR_Address,  adr, iore, ramadr, ramre, dm_sel);
  assign vec_re  = reg_hit(XVEC_Address,  adr, iore, ramadr, ramre, dm_sel);
  assign hold_re = reg_hit(XHOLD_Address, adr, iore, ramadr, ramre, dm_sel);

  logic             en;
  logic [WIDTH-1:0] xmsk, xmode, xifr, hist;
  logic [7:0]       xhold, hold_cnt;

  logic [WIDTH-1:0] set_v, clr_v, cand;
  logic [7:0]       ifr8, msk8, ack_onehot;
  logic [2:0]       win;
  logic             found, ack_fire, vec_live;

  assign ifr8       = 8'(xifr);
  assign msk8       = 8'(xmsk);
  assign ack_fire   = x_irq & x_irq_ack;
  assign ack_onehot = ack_fire ? (8'd1 << x_irq_vec) : '0;
  assign vec_live   = ifr8[x_irq_vec] & msk8[x_irq_vec] & en;
  assign cand       = xifr & xmsk;

  // Set terms are OR-ed after clears so a simultaneous set always wins.
  assign set_v = (x_int_in & ~xmode) | (x_int_in & xmode & ~hist);
  assign clr_v = (ifr_we ? dbus_in[WIDTH-1:0] : '0)
               | ((ctl_we && dbus_in[1]) ? '1 : '0)
               | ack_onehot[WIDTH-1:0];

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cand[i] && !found) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en        <= 1'b0;
      xmsk      <= '0;
      xmode     <= '0;
      xifr      <= '0;
      hist      <= '0;
      xhold     <= '0;
      hold_cnt  <= '0;
      x_irq     <= 1'b0;
      x_irq_vec <= '0;
    end else begin
      hist <= x_int_in;
      xifr <= (xifr & ~clr_v) | set_v;
      if (ctl_we)  en    <= dbus_in[0];
      if (msk_we)  xmsk  <= dbus_in[WIDTH-1:0];
      if (mode_we) xmode <= dbus_in[WIDTH-1:0];
      if (hold_we) xhold <= dbus_in;

      if (ack_fire)             hold_cnt <= xhold;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 8'd1;

      // Vector is frozen while a request is outstanding; only ack or loss of
      // the vectored source's flag/mask/enable retires it.
      if (x_irq) begin
        if (ack_fire || !vec_live) x_irq <= 1'b0;
      end else if (en && (hold_cnt == '0) && found) begin
        x_irq     <= 1'b1;
        x_irq_vec <= win;
      end
    end
  end

  always_comb begin
    dbus_out = '0;
    out_en   = ctl_re | msk_re | mode_re | ifr_re | vec_re | hold_re;
    if (ctl_re)       dbus_out = {7'b0, en};
    else if (msk_re)  dbus_out = 8'(xmsk);
    else if (mode_re) dbus_out = 8'(xmode);
    else if (ifr_re)  dbus_out = 8'(xifr);
    else if (vec_re)  dbus_out = {x_irq, 4'b0, x_irq_vec};
    else if (hold_re) dbus_out = xhold;
  end

endmodule

// File: doc/xlr8_irq_ctl.md
# xlr8_irq_ctl

Parametrised interrupt controller that collects up to eight internal interrupt sources and drives one vectored request into the AVR core. It adds per-channel level/edge mode, a fixed-priority vector, a single-request ack handshake with a programmable holdoff, and software-visible pending flags. It sits on the I/O and DM register bus beside the other XLR8 peripherals.

## Interface

- WIDTH, 8, number of channels (1..8); unused register bits read 0.
- XCTL_Address, 0, control register: bit0 global enable, bit1 write-1 clears all flags (self-clearing, reads 0).
- XMSK_Address, 0, per-channel enable mask.
- XMODE_Address, 0, per-channel mode: 1 = rising edge, 0 = level.
- XIFR_Address, 0, pending flags; write-1-to-clear.
- XVEC_Address, 0, read-only: bit7 = x_irq, bits[2:0] = x_irq_vec; writes ignored.
- XHOLD_Address, 0, 8-bit holdoff cycle count after ack.
- Register placement for every address parameter: address >= 0x60 uses ramadr/ramre/ramwe qualified by dm_sel; otherwise adr/iore/iowe.
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- adr  in  6  I/O address.
- iowe, iore  in  1  I/O write/read strobes.
- dbus_in  in  8  write data.
- dbus_out  out  8  read data; 0 when no register is selected for read.
- out_en  out  1  high while any register in this block is read.
- ramadr  in  8; ramre, ramwe, dm_sel  in  1  DM bus.
- x_int_in  in  WIDTH  synchronous interrupt sources.
- x_irq  out  1  registered request to the core.
- x_irq_vec  out  3  registered index of the channel being requested.
- x_irq_ack  in  1  one-cycle ack from the core.

## Operation

- Reset: all registers 0, edge-history 0, holdoff counter 0, x_irq = 0, x_irq_vec = 0, dbus_out = 0, out_en = 0.
- Flag set, per channel i: level mode sets xifr[i] on every cycle x_int_in[i] = 1. Edge mode sets it when x_int_in[i] = 1 and the previous-cycle sample = 0. The history register updates every cycle regardless of mode.
- The mask does not gate flag setting. Flags latch for polling; the mask only gates requests.
- Flag clear: by XIFR write-1, by XCTL bit1, or by the ack of the vectored channel. A set condition in the same cycle as any clear wins, and the flag stays 1. A level source still high therefore re-pends immediately.
- Candidates are xifr & xmsk. Priority is fixed: the lowest index wins.
- Request: when x_irq = 0, XCTL.bit0 = 1, holdoff = 0, and candidates are nonzero, set x_irq = 1 and x_irq_vec = the winning index on the next edge.
- While x_irq = 1, x_irq_vec is frozen (no preemption).
- x_irq drops with no ack, leaving the flag intact, if any of these occurs: the vectored flag is cleared by software, its mask bit goes 0, or the enable goes 0.
- Ack: x_irq_ack = 1 while x_irq = 1 does the following on that edge: clears xifr[x_irq_vec] (subject to the set-wins rule), sets x_irq = 0, and loads the holdoff counter with XHOLD.
- An ack while x_irq = 0 is ignored.
- Holdoff: the counter decrements to 0 once per cycle. Requests are blocked while it is nonzero.
- Register writes take effect on the clock edge. Reads are combinational from current register values.

## Timing

- Edge-mode latency: x_int_in rises before edge n → xifr set at n → x_irq/x_irq_vec valid at n+1.
- Ack at edge k → x_irq = 0 after k. The earliest re-assertion is edge k+1+XHOLD.
- With XHOLD = 0, a still-pending channel re-requests at edge k+1.
- Software clear of the vectored flag at edge k drops x_irq at edge k+1.
- Asynchronous reset mid-request forces x_irq = 0 immediately and discards the holdoff count.

## Test plan

- Reset values: after rstn, all six registers read 0 and x_irq = 0. XVEC reads 0x00 with out_en = 1.
- Priority: XMSK = 0xFF, XCTL = 1, XMODE = 0. Hold x_int_in = 0x24 → x_irq_vec = 2. Ack → vec 2 flag re-pends (level still high). With XHOLD = 0, the next request is vec 2 again. Drop bit2 and ack → the next request is vec 5.
- Edge mode: XMODE = 0x01. Pulse x_int_in[0] for one cycle, then hold it high → exactly one flag set and one request. Ack → XIFR = 0x00 and no further request.
- Holdoff: XHOLD = 3, channels 1 and 3 pending, ack at edge k → x_irq low during k+1..k+3, then high at k+4 with vec 3.
- Mask/enable: with a flag pending and XMSK = 0, XIFR reads it set and x_irq = 0. Set XMSK → x_irq after one edge. Clear XCTL.bit0 → x_irq drops and the flag is retained.
- Simultaneous events: an XIFR write of 0x01 in the same cycle as an edge event on channel 0 → flag remains 1. An ack while x_irq = 0 → no state change.
